// File: rtl/vga_saver_sched.sv
// Frame-based screen-saver scheduler: counts idle frames from vertical sync and
// sequences ACTIVE -> BLANK_IN -> SAVER -> BLANK_OUT -> ACTIVE, driving mux/blank/saver controls.
module vga_saver_sched #(
  parameter int unsigned IDLE_FRAMES     = 1800,
  parameter int unsigned BLANK_FRAMES    = 2,
  parameter int unsigned SPEED_UP_FRAMES = 600,
  parameter int unsigned PAL_FRAMES      = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs_in,
  input  logic       activity,
  input  logic       saver_en,
  input  logic       force_saver,
  output logic       frame_tick,
  output logic       sel_saver,
  output logic       blank,
  output logic       saver_run,
  output logic       saver_rst,
  output logic [1:0] speed,
  output logic [1:0] palette_idx,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_BLANK_IN  = 2'd1,
    ST_SAVER     = 2'd2,
    ST_BLANK_OUT = 2'd3
  } state_e;

  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_FRAMES - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_FRAMES - 1);
  localparam logic [15:0] SPD_LAST   = 16'(SPEED_UP_FRAMES - 1);
  localparam logic [15:0] PAL_LAST   = 16'(PAL_FRAMES - 1);

  // Synchroniser stages reset high (vs idle level) so reset release never fakes a fall.
  logic vs_s1_q, vs_s2_q, vs_d_q, tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_d_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vs_s1_q <= vs_in;
      vs_s2_q <= vs_s1_q;
      vs_d_q  <= vs_s2_q;
      tick_q  <= vs_d_q & ~vs_s2_q;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [15:0] spd_cnt_q, spd_cnt_d;
  logic [15:0] pal_cnt_q, pal_cnt_d;
  logic [1:0]  speed_q, speed_d;
  logic [1:0]  pal_q, pal_d;
  logic        rst_q, rst_d;
  logic        sel_q, sel_d;
  logic        blank_q, blank_d;
  logic        run_q, run_d;

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    bcnt_d    = bcnt_q;
    spd_cnt_d = spd_cnt_q;
    pal_cnt_d = pal_cnt_q;
    speed_d   = speed_q;
    pal_d     = pal_q;
    rst_d     = 1'b0;
    unique case (state_q)
      ST_ACTIVE: begin
        // Activity wins over a tick arriving in the same cycle.
        if (activity) begin
          idle_d = '0;
        end else if (tick_q && (idle_q != 16'hFFFF)) begin
          idle_d = idle_q + 16'd1;
        end
        if (saver_en && (force_saver || (tick_q && !activity && (idle_q == IDLE_LAST)))) begin
          state_d = ST_BLANK_IN;
          rst_d   = 1'b1;
          bcnt_d  = '0;
          speed_d = '0;
          pal_d   = '0;
        end
      end
      ST_BLANK_IN: begin
        if (!saver_en || (activity && !force_saver)) begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
        end else if (tick_q) begin
          if (bcnt_q == BLANK_LAST) begin
            state_d   = ST_SAVER;
            spd_cnt_d = '0;
            pal_cnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      ST_SAVER: begin
        if (!saver_en || (activity && !force_saver)) begin
          state_d = ST_BLANK_OUT;
          bcnt_d  = '0;
        end else if (tick_q) begin
          if (spd_cnt_q == SPD_LAST) begin
            spd_cnt_d = '0;
            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
          end else begin
            spd_cnt_d = spd_cnt_q + 16'd1;
          end
          if (pal_cnt_q == PAL_LAST) begin
            pal_cnt_d = '0;
            pal_d     = pal_q + 2'd1;
          end else begin
            pal_cnt_d = pal_cnt_q + 16'd1;
          end
        end
      end
      ST_BLANK_OUT: begin
        if (tick_q) begin
          if (bcnt_q == BLANK_LAST) begin
            state_d = ST_ACTIVE;
            idle_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    // Mux controls are decoded from the next state so they register alongside it.
    sel_d   = (state_d == ST_SAVER);
    blank_d = (state_d == ST_BLANK_IN) || (state_d == ST_BLANK_OUT);
    run_d   = (state_d == ST_SAVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACTIVE;
      idle_q    <= '0;
      bcnt_q    <= '0;
      spd_cnt_q <= '0;
      pal_cnt_q <= '0;
      speed_q   <= '0;
      pal_q     <= '0;
      rst_q     <= 1'b0;
      sel_q     <= 1'b0;
      blank_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      bcnt_q    <= bcnt_d;
      spd_cnt_q <= spd_cnt_d;
      pal_cnt_q <= pal_cnt_d;
      speed_q   <= speed_d;
      pal_q     <= pal_d;
      rst_q     <= rst_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      run_q     <= run_d;
    end
  end

  assign frame_tick  = tick_q;
  assign sel_saver   = sel_q;
  assign blank       = blank_q;
  assign saver_run   = run_q;
  assign saver_rst   = rst_q;
  assign speed       = speed_q;
  assign palette_idx = pal_q;
  assign state       = state_q;

endmodule
